alu_result_serializer: RTL and testbench
========================================

// Module: alu_result_serializer
// PURPOSE
//  Output stage of the ALU datapath. Captures a DATA_W-bit ALU result and presents it
//  on a narrower BUS_W-bit output bus, one block at a time.
//  Two modes: HOLD (block chosen by a select input, as a random-access register) and
//  STREAM (blocks sent automatically, most-significant block first, under a valid/ready handshake).
//  Sits between the ALU core and the 8-bit external/output bus.
// PARAMETERS
//  DATA_W  16  width of captured ALU result; DATA_W % BUS_W == 0 (elaboration $error otherwise)
//  BUS_W   8   output bus width
//  NBLK    DATA_W/BUS_W (localparam)  number of blocks; SEL_W = max(1,$clog2(NBLK))
// PORTS
//  clk        in   1       clock, rising edge
//  rst_n      in   1       asynchronous reset, active-low
//  load       in   1       capture data_in / mode_in this cycle
//  data_in    in   DATA_W  ALU result
//  mode_in    in   1       0 = HOLD, 1 = STREAM; sampled only on an accepted load
//  sel_blk    in   SEL_W   HOLD mode block select; 0 = most-significant block
//  out_data   out  BUS_W   registered output block
//  out_valid  out  1       out_data is meaningful
//  out_ready  in   1       STREAM consumer accepts the block when out_valid & out_ready
//  out_last   out  1       current block is the least-significant block (index NBLK-1)
//  busy       out  1       STREAM transfer in progress
//  overrun    out  1       sticky: a load was rejected while busy
//  clr_ovr    in   1       synchronous clear of overrun
// BEHAVIOUR
//  - Reset (async, rst_n=0): state IDLE. Capture register = 0. Block index = 0.
//    out_data, out_valid, out_last, busy and overrun are all 0. Clock-independent.
//  - States: IDLE, HOLD, STREAM. All outputs are registered.
//  - IDLE: on load -> capture data_in. Next state is HOLD if mode_in=0, STREAM if mode_in=1.
//  - HOLD: out_valid=1.
//    - out_data = block[sel_blk], with 1-cycle latency from a sel_blk change or from the load.
//    - out_last = (sel_blk == NBLK-1).
//    - sel_blk >= NBLK (NBLK not a power of 2): out_data = 0 and out_last = 0.
//    - out_ready is ignored. busy = 0.
//    - load in HOLD: recapture and re-evaluate mode_in; an immediate switch to STREAM is allowed.
//  - STREAM: busy=1. out_valid=1 from the cycle after the load.
//    - The block index starts at 0. On each out_valid & out_ready the index increments and
//      out_data advances on the next edge.
//    - With out_ready low, out_data, out_last and out_valid hold stable (AXI-style: valid is
//      never withdrawn without a handshake).
//    - Handshake on the block with out_last=1 -> IDLE; out_valid, busy and out_last go 0 next cycle.
//  - load while busy, without a final handshake in the same cycle: rejected. The capture
//    register is unchanged and overrun is set on the next edge.
//  - load in the same cycle as the final-block handshake: accepted (back-to-back), no overrun.
//    The first block of the new word appears on the next cycle and out_valid stays 1.
//  - clr_ovr and a rejected load in the same cycle: set wins (overrun stays 1).
//  - NBLK==1: a STREAM transfer is one block with out_last=1. In HOLD, out_last is always 1.
//  - Throughput: 1 block/cycle with out_ready held high. Latency load -> first block = 1 cycle.
// STRUCTURE
//  - Shared package alu_out_pkg:
//    - typedef enum logic [1:0] {S_IDLE, S_HOLD, S_STREAM} ser_state_t;
//    - typedef enum logic {M_HOLD, M_STREAM} ser_mode_t;
//  - Sub-module block_slice_mux #(DATA_W,BUS_W): combinational; word + index -> BUS_W slice,
//    index 0 = MSBs, out-of-range index returns 0. Reused by the HOLD and STREAM paths.
//  - Top holds the FSM, capture register, index counter and output registers.
// TESTING (DATA_W=16, BUS_W=8)
//  1. Reset: drive rst_n=0 mid-cycle -> all outputs 0 immediately. Hold after release with no load.
//  2. HOLD: load 0xA55A, mode 0, sel 0 -> next cycle out_data=0xA5, valid=1, last=0.
//     sel 1 -> one cycle later 0x5A, last=1.
//  3. STREAM, ready=1: load 0x1234 -> 0x12 (last=0), then 0x34 (last=1), then valid=0, busy=0.
//  4. Backpressure: load 0xBEEF, ready=0 for 3 cycles -> out_data=0xBE stable with valid=1.
//     ready=1 -> 0xEF, then idle.
//  5. Overrun: load 0x1234 (STREAM), ready=0, then load 0xFFFF -> overrun=1 and stream still
//     0x12, 0x34. clr_ovr -> overrun=0.
//  6. Back-to-back: load 0xCAFE on the 0x34 handshake -> 0xCA, 0xFE follow, valid never drops,
//     overrun=0.

Source files
------------

// File: rtl/alu_out_pkg.sv
// alu_out_pkg: shared types for the ALU output serializer.
//   ser_state_t : serializer FSM state (idle / random-access hold / streaming)
//   ser_mode_t  : mode requested alongside a load (mode_in)
package alu_out_pkg;

  typedef enum logic [1:0] {S_IDLE, S_HOLD, S_STREAM} ser_state_t;
  typedef enum logic {M_HOLD, M_STREAM} ser_mode_t;

endpackage

// File: rtl/block_slice_mux.sv
// block_slice_mux: picks one BUS_W-wide block out of a DATA_W-wide word.
//   word  in  DATA_W  source word
//   idx   in  SEL_W   block index, 0 = most-significant block
//   slice out BUS_W   selected block, 0 when idx >= NBLK
module block_slice_mux #(
  parameter  int DATA_W = 16,
  parameter  int BUS_W  = 8,
  localparam int NBLK   = DATA_W / BUS_W,
  localparam int SEL_W  = (NBLK > 1) ? $clog2(NBLK) : 1
) (
  input  logic [DATA_W-1:0] word,
  input  logic [SEL_W-1:0]  idx,
  output logic [BUS_W-1:0]  slice
);

  always_comb begin
    slice = '0;
    for (int i = 0; i < NBLK; i++) begin
      if (idx == SEL_W'(i)) slice = word[DATA_W-1-i*BUS_W -: BUS_W];
    end
  end

endmodule

// File: rtl/alu_result_serializer.sv
// alu_result_serializer: captures an ALU result and presents it BUS_W bits at a
// time, either as a random-access register (HOLD) or as an MSB-first stream
// under a valid/ready handshake (STREAM).
//   clk, rst_n          clock / async active-low reset
//   load, data_in       capture request and ALU result
//   mode_in             0 = HOLD, 1 = STREAM (sampled on an accepted load)
//   sel_blk             HOLD block select, 0 = MS block
//   out_data/valid/last registered output block, valid, last-block flag
//   out_ready           STREAM consumer ready
//   busy                STREAM transfer in progress
//   overrun, clr_ovr    sticky rejected-load flag and its synchronous clear
module alu_result_serializer
  import alu_out_pkg::*;
#(
  parameter  int DATA_W = 16,
  parameter  int BUS_W  = 8,
  localparam int NBLK   = DATA_W / BUS_W,
  localparam int SEL_W  = (NBLK > 1) ? $clog2(NBLK) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DATA_W-1:0] data_in,
  input  logic              mode_in,
  input  logic [SEL_W-1:0]  sel_blk,
  output logic [BUS_W-1:0]  out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              overrun,
  input  logic              clr_ovr
);

  if ((DATA_W % BUS_W) != 0 || DATA_W < BUS_W) begin : g_bad_width
    $error("alu_result_serializer: DATA_W must be a non-zero multiple of BUS_W");
  end

  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NBLK - 1);

  ser_state_t         state_q, state_d;
  logic [DATA_W-1:0]  cap_q, cap_d;
  logic [SEL_W-1:0]   idx_q, idx_d;
  logic [BUS_W-1:0]   data_q, data_d;
  logic               valid_q, valid_d;
  logic               last_q, last_d;
  logic               busy_q, busy_d;
  logic               ovr_q, ovr_d;

  logic               hs, fin, load_ok;
  logic [SEL_W-1:0]   sel_idx;
  logic [BUS_W-1:0]   slice;

  // Outputs are computed from the *next* state/capture so that the block
  // appears one cycle after the load or the sel_blk / index change.
  block_slice_mux #(.DATA_W(DATA_W), .BUS_W(BUS_W)) u_mux (
    .word  (cap_d),
    .idx   (sel_idx),
    .slice (slice)
  );

  always_comb begin
    state_d = state_q;
    cap_d   = cap_q;
    idx_d   = idx_q;
    ovr_d   = ovr_q;

    // valid is always high in STREAM, so ready alone forms the handshake
    hs      = (state_q == S_STREAM) && out_ready;
    fin     = hs && last_q;
    load_ok = load && ((state_q != S_STREAM) || fin);

    if (clr_ovr)          ovr_d = 1'b0;
    if (load && !load_ok) ovr_d = 1'b1;   // set beats clear

    case (state_q)
      S_STREAM: if (hs) begin
        if (last_q) state_d = S_IDLE;
        else        idx_d   = idx_q + SEL_W'(1);
      end
      default: ;
    endcase

    if (load_ok) begin
      cap_d   = data_in;
      idx_d   = '0;
      state_d = (ser_mode_t'(mode_in) == M_STREAM) ? S_STREAM : S_HOLD;
    end

    if (NBLK == 1)               sel_idx = '0;
    else if (state_d == S_HOLD)  sel_idx = sel_blk;
    else                         sel_idx = idx_d;

    valid_d = (state_d != S_IDLE);
    busy_d  = (state_d == S_STREAM);
    // out-of-range sel never equals LAST_IDX, so last drops with the data
    last_d  = valid_d && ((NBLK == 1) || (sel_idx == LAST_IDX));
    data_d  = valid_d ? slice : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cap_q   <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cap_q   <= cap_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      ovr_q   <= ovr_d;
    end
  end

  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign out_last  = last_q;
  assign busy      = busy_q;
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_alu_result_serializer.sv
// Bench for alu_result_serializer (DATA_W=16, BUS_W=8). Stimulus pushes the
// expected block for every cycle in which out_valid & out_ready will be seen;
// the negedge monitor pops and compares on every such cycle.
module tb_alu_result_serializer;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
    logic       busy;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        load = 1'b0;
  logic [15:0] data_in = '0;
  logic        mode_in = 1'b0;
  logic [0:0]  sel_blk = '0;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        out_last;
  logic        busy;
  logic        overrun;
  logic        clr_ovr = 1'b0;

  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  alu_result_serializer #(.DATA_W(16), .BUS_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .data_in(data_in), .mode_in(mode_in),
    .sel_blk(sel_blk), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .busy(busy), .overrun(overrun), .clr_ovr(clr_ovr)
  );

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic push(input logic [7:0] d, input logic l, input logic b);
    exp_t e;
    e.data = d; e.last = l; e.busy = b;
    sb.push_back(e);
  endtask

  // monitor: one pop per observed transfer
  always @(negedge clk) begin
    if (rst_n && out_valid === 1'b1 && out_ready === 1'b1) begin
      exp_t e;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_block: got data=%h last=%b busy=%b, none expected",
                 out_data, out_last, busy);
      end else begin
        e = sb.pop_front();
        if ({out_data, out_last, busy} !== {e.data, e.last, e.busy}) begin
          errors++;
          $display("FAIL block: got data=%h last=%b busy=%b expected data=%h last=%b busy=%b",
                   out_data, out_last, busy, e.data, e.last, e.busy);
        end
      end
    end
  end

  initial begin
    // 1. asynchronous reset mid-cycle
    #3 rst_n = 1'b0;
    #1;
    chk("reset_outputs", {4'h0, out_data, out_valid, out_last, busy, overrun},
        {4'h0, 8'h00, 4'h0});
    step(); step();
    rst_n = 1'b1;
    step(); step();
    chk("idle_after_reset", {4'h0, out_data, out_valid, out_last, busy, overrun},
        {4'h0, 8'h00, 4'h0});

    // 2. HOLD random access
    out_ready = 1'b1;
    load = 1'b1; data_in = 16'hA55A; mode_in = 1'b0; sel_blk = 1'b0;
    step();
    load = 1'b0; sel_blk = 1'b1;
    push(8'hA5, 1'b0, 1'b0);
    step();
    push(8'h5A, 1'b1, 1'b0);
    // 3. STREAM from HOLD, ready high
    load = 1'b1; data_in = 16'h1234; mode_in = 1'b1;
    step();
    load = 1'b0;
    push(8'h12, 1'b0, 1'b1);
    step();
    push(8'h34, 1'b1, 1'b1);
    step();
    chk("stream_end_idle", {14'h0, out_valid, busy}, 16'h0);

    // 4. backpressure
    out_ready = 1'b0;
    load = 1'b1; data_in = 16'hBEEF; mode_in = 1'b1;
    step();
    load = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_hold", {6'h0, out_data, out_valid, out_last}, {6'h0, 8'hBE, 2'b10});
    end
    out_ready = 1'b1;
    push(8'hBE, 1'b0, 1'b1);
    step();
    push(8'hEF, 1'b1, 1'b1);
    step();
    chk("bp_end_idle", {14'h0, out_valid, busy}, 16'h0);

    // 5. overrun
    out_ready = 1'b0;
    load = 1'b1; data_in = 16'h1234; mode_in = 1'b1;
    step();
    data_in = 16'hFFFF;             // rejected load
    step();
    load = 1'b0;
    chk("overrun_set", {7'h0, out_data, overrun}, {7'h0, 8'h12, 1'b1});
    out_ready = 1'b1;
    push(8'h12, 1'b0, 1'b1);
    step();
    push(8'h34, 1'b1, 1'b1);
    step();
    chk("overrun_sticky", {15'h0, overrun}, 16'h1);
    clr_ovr = 1'b1;
    step();
    clr_ovr = 1'b0;
    chk("overrun_clear", {15'h0, overrun}, 16'h0);

    // clear and reject together: set wins
    out_ready = 1'b0;
    load = 1'b1; data_in = 16'h1234; mode_in = 1'b1;
    step();
    clr_ovr = 1'b1; data_in = 16'h0F0F;
    step();
    load = 1'b0; clr_ovr = 1'b0;
    chk("set_beats_clear", {15'h0, overrun}, 16'h1);
    out_ready = 1'b1; clr_ovr = 1'b1;
    push(8'h12, 1'b0, 1'b1);
    step();
    clr_ovr = 1'b0;
    push(8'h34, 1'b1, 1'b1);
    step();

    // 6. back-to-back
    load = 1'b1; data_in = 16'h1234; mode_in = 1'b1;
    step();
    load = 1'b0;
    push(8'h12, 1'b0, 1'b1);
    step();
    push(8'h34, 1'b1, 1'b1);
    load = 1'b1; data_in = 16'hCAFE;
    step();
    load = 1'b0;
    chk("b2b_valid_kept", {15'h0, out_valid}, 16'h1);
    push(8'hCA, 1'b0, 1'b1);
    step();
    push(8'hFE, 1'b1, 1'b1);
    step();
    chk("b2b_end", {13'h0, out_valid, busy, overrun}, 16'h0);

    step();
    chk("scoreboard_drained", 16'(sb.size()), 16'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
